// File: rtl/ab_tx_if.sv
// Word handshake into the AB link transmitter.
// master: producer drives in_data/in_valid; slave: ab_tx returns in_ready.
interface ab_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/ab_tx.sv
// Transmit end of the 5-lane redundant bit link: serialises words MSB-first
// as replicated 5-lane symbols and counts voter feedback mismatches.
// Ports: clk, rst_n (sync, active-low), in_if (word handshake),
// fault_mask (lane XOR), x_out/x_valid (symbol), z_fb (voter decision),
// err_clr/err_cnt (saturating mismatch count), frame_done (end pulse).
module ab_tx #(
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  ab_tx_if.slave     in_if,
  input  logic [4:0] fault_mask,
  output logic [4:0] x_out,
  output logic       x_valid,
  input  logic       z_fb,
  input  logic       err_clr,
  output logic [7:0] err_cnt,
  output logic       frame_done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic [3:0]        hold_q, hold_d;
  logic [4:0]        mask_q, mask_d;
  logic [4:0]        x_q, x_d;
  logic              xv_q, xv_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;
  logic [7:0]        err_q, err_d;
  logic              cur_bit;
  logic              last_hold;
  logic              inc;

  // The word is shifted left so the bit on the wire is always the MSB.
  assign cur_bit   = sh_q[DATA_W-1];
  assign last_hold = (hold_q == 4'(HOLD_CYC - 1));

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    mask_d  = mask_q;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          sh_d    = in_if.in_data;
          bit_d   = IW'(DATA_W - 1);
          hold_d  = '0;
          mask_d  = fault_mask;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_hold) begin
          // Judged against the unmasked bit, not x_out.
          inc = (z_fb != cur_bit);
          if (bit_q == '0) begin
            state_d = DONE;
          end else begin
            bit_d  = bit_q - IW'(1);
            sh_d   = {sh_q[DATA_W-2:0], 1'b0};
            hold_d = '0;
            mask_d = fault_mask;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from next-state values.
    rdy_d  = (state_d == IDLE);
    xv_d   = (state_d == SEND);
    done_d = (state_d == DONE);
    x_d    = xv_d ? ({5{sh_d[DATA_W-1]}} ^ mask_d) : 5'b00000;

    // Clear wins over a same-edge increment.
    err_d = err_q;
    if (err_clr) begin
      err_d = 8'd0;
    end else if (inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      mask_q  <= '0;
      x_q     <= '0;
      xv_q    <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_if.in_ready = rdy_q;
  assign x_out          = x_q;
  assign x_valid        = xv_q;
  assign frame_done     = done_q;
  assign err_cnt        = err_q;

endmodule
